// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback always wins, one aux result
// is buffered until a free slot appears, and a stall is requested if it starves.
module wb_port_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_wreg,
    input  logic              aux_valid,
    input  logic [ADDR_W-1:0] aux_wd,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [ADDR_W-1:0] buf_wd;
    logic [DATA_W-1:0] buf_wdata;

    logic              slot_busy;
    logic              xfer;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // A pipeline write to r0 is architecturally a no-op, so it leaves the slot free.
    assign slot_busy = wb_wreg && (wb_wd != '0);
    assign aux_ready = (state == IDLE) && rst;
    assign xfer      = aux_valid && aux_ready;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = wb_wd;
        sel_data = wb_wdata;
        if (slot_busy) begin
            sel_we = 1'b1;
        end else if (state != IDLE) begin
            sel_we   = (buf_wd != '0);
            sel_addr = buf_wd;
            sel_data = buf_wdata;
        end else if (xfer) begin
            sel_we   = (aux_wd != '0);
            sel_addr = aux_wd;
            sel_data = aux_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            stall_req <= 1'b0;
        end else begin
            rf_we     <= sel_we;
            if (sel_we) begin
                rf_waddr <= sel_addr;
                rf_wdata <= sel_data;
            end
            // Lags FORCE by one edge: raised the cycle after entry, dropped the cycle after drain.
            stall_req <= (state == FORCE);

            case (state)
                IDLE: begin
                    if (xfer && slot_busy) begin
                        wait_cnt <= 4'd1;
                        state    <= (MAX_WAIT == 1) ? FORCE : PEND;
                    end
                end
                PEND, FORCE: begin
                    if (!slot_busy) begin
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        if (wait_cnt < MAX_CNT)
                            wait_cnt <= wait_cnt + 4'd1;
                        if (wait_cnt >= MAX_CNT - 4'd1)
                            state <= FORCE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the buffer payload has no reset; it is only read while state says it is valid.
    always_ff @(posedge clk) begin
        if (state == IDLE && xfer && slot_busy) begin
            buf_wd    <= aux_wd;
            buf_wdata <= aux_wdata;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed literal checks plus randomized traffic compared
// every cycle against a queue-based behavioural model of the write-port arbiter.
module tb_wb_port_arbiter;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] wb_wd;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_wreg;
    logic              aux_valid;
    logic [ADDR_W-1:0] aux_wd;
    logic [DATA_W-1:0] aux_wdata;
    logic              aux_ready;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              stall_req;

    int n_checks = 0;
    int n_pass   = 0;

    wb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_wd     (wb_wd),
        .wb_wdata  (wb_wdata),
        .wb_wreg   (wb_wreg),
        .aux_valid (aux_valid),
        .aux_wd    (aux_wd),
        .aux_wdata (aux_wdata),
        .aux_ready (aux_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [ADDR_W-1:0] wd;
        logic [DATA_W-1:0] wdata;
    } wr_t;

    wr_t               pend[$];
    int                waits    = 0;
    bit                starved  = 0;
    bit                m_valid  = 0;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              e_stall;

    function automatic void m_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        e_we = (a != 0);
        if (a != 0) begin
            e_addr = a;
            e_data = d;
        end
    endfunction

    // Inputs are driven just after posedge, so at negedge they are the values the next edge samples.
    always @(negedge clk) begin
        bit  busy;
        bit  xfer;
        wr_t w;
        if (m_valid) begin
            check("rf_we", rf_we, e_we);
            check("stall_req", stall_req, e_stall);
            if (e_we) begin
                check("rf_waddr", rf_waddr, e_addr);
                check("rf_wdata", rf_wdata, e_data);
            end
        end
        check("aux_ready", aux_ready, rst && pend.size() == 0);

        busy = wb_wreg && wb_wd != 0;
        if (!rst) begin
            pend.delete();
            waits   = 0;
            starved = 0;
            e_we    = 0;
            e_addr  = 0;
            e_data  = 0;
            e_stall = 0;
        end else begin
            e_stall = starved;
            xfer    = aux_valid && pend.size() == 0;
            if (busy) m_write(wb_wd, wb_wdata);
            else if (pend.size() != 0) begin
                w = pend.pop_front();
                m_write(w.wd, w.wdata);
            end else if (xfer) m_write(aux_wd, aux_wdata);
            else e_we = 0;

            if (xfer && busy) begin
                w.wd    = aux_wd;
                w.wdata = aux_wdata;
                pend.push_back(w);
                waits = 1;
            end else if (pend.size() != 0) begin
                waits = (waits + 1 > MAX_WAIT) ? MAX_WAIT : waits + 1;
            end
            if (pend.size() == 0) waits = 0;
            starved = (pend.size() != 0) && (waits >= MAX_WAIT);
        end
        m_valid = 1;
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic wreg, input logic [ADDR_W-1:0] wd, input logic [DATA_W-1:0] wdata,
                         input logic av, input logic [ADDR_W-1:0] awd, input logic [DATA_W-1:0] awdata);
        wb_wreg   = wreg;
        wb_wd     = wd;
        wb_wdata  = wdata;
        aux_valid = av;
        aux_wd    = awd;
        aux_wdata = awdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1, 5'd4, 32'h1, 1, 5'd6, 32'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_we", rf_we, 0);
            check("rst_waddr", rf_waddr, 0);
            check("rst_wdata", rf_wdata, 0);
            check("rst_stall", stall_req, 0);
            check("rst_ready", aux_ready, 0);
        end
        step();

        // Plain pipe write, then a pipe write to r0 that must be dropped.
        rst = 1'b1;
        drive(1, 5'd5, 32'h1234, 0, 0, 0);
        step();
        check("pipe_we", rf_we, 1);
        check("pipe_addr", rf_waddr, 5);
        check("pipe_data", rf_wdata, 32'h1234);
        drive(1, 5'd0, 32'h9999, 0, 0, 0);
        step();
        check("r0_we", rf_we, 0);
        check("r0_hold_addr", rf_waddr, 5);
        check("r0_hold_data", rf_wdata, 32'h1234);

        // Aux bypass into a free slot.
        drive(0, 0, 0, 1, 5'd7, 32'hDEAD);
        #1 check("byp_ready", aux_ready, 1);
        step();
        check("byp_we", rf_we, 1);
        check("byp_addr", rf_waddr, 7);
        check("byp_data", rf_wdata, 32'hDEAD);
        drive(0, 0, 0, 0, 0, 0);
        #1 check("byp_idle_ready", aux_ready, 1);

        // Collision: pipe first, buffered aux on the next free slot.
        drive(1, 5'd3, 32'h3333, 1, 5'd9, 32'hAAAA);
        #1 check("col_ready0", aux_ready, 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        check("col_we1", rf_we, 1);
        check("col_addr1", rf_waddr, 3);
        check("col_data1", rf_wdata, 32'h3333);
        check("col_ready1", aux_ready, 0);
        step();
        check("col_we2", rf_we, 1);
        check("col_addr2", rf_waddr, 9);
        check("col_data2", rf_wdata, 32'hAAAA);
        check("col_ready2", aux_ready, 1);

        // Starvation: stall_req appears after the 5th edge counted from the load edge.
        drive(1, 5'd1, 32'h100, 1, 5'd10, 32'hBBBB);
        for (int i = 0; i < 6; i++) begin
            step();
            drive(1, 5'd1, 32'h101 + i, 0, 0, 0);
            check("starve_stall", stall_req, (i >= 4) ? 1 : 0);
            check("starve_pipe", rf_waddr, 1);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("drain_we", rf_we, 1);
        check("drain_addr", rf_waddr, 10);
        check("drain_data", rf_wdata, 32'hBBBB);
        check("drain_stall_hi", stall_req, 1);
        step();
        check("drain_stall_lo", stall_req, 0);

        // Reset while an aux result is buffered: it must vanish.
        drive(1, 5'd3, 32'h3, 1, 5'd11, 32'hCCCC);
        step();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("midrst_we", rf_we, 0);
        rst = 1'b1;
        #1 check("midrst_ready", aux_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_noaux", rf_we, 0);
        end

        // Randomized traffic; busy bias alternates to provoke starvation phases.
        for (int i = 0; i < 4000; i++) begin
            int busy_pct;
            busy_pct = ((i / 200) % 2 == 0) ? 40 : 90;
            rst = ($urandom_range(99) < 2) ? 1'b0 : 1'b1;
            drive($urandom_range(99) < busy_pct,
                  ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
                  $urandom(),
                  $urandom_range(1),
                  ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31)),
                  $urandom());
            step();
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
